// File: rtl/rs_dec_chien_forney.sv
`default_nettype none
// ============================================================================
// Module      : rs_dec_chien_forney
// Description : Chien search plus Forney error-value stage for the CIRC C1
//               RS(32,28) decoder over GF(2^8), poly 0x11D, alpha = 0x02.
//               Inverts lambda1 by repeated squaring (7 cycles), then scans
//               the 32 codeword positions one per cycle, streaming located
//               errors and finally a done/fail verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_dec_chien_forney (
    input  logic       i_clk,
    input  logic       i_resb,
    input  logic       i_start,
    input  logic [7:0] i_lambda1,
    input  logic [7:0] i_lambda2,
    input  logic [7:0] i_omega0,
    input  logic [7:0] i_omega1,
    output logic       o_err_valid,
    output logic [4:0] o_err_pos,
    output logic [7:0] o_err_val,
    output logic       o_done,
    output logic       o_fail,
    output logic       o_busy
);

    // Reduction term for x^8 = x^4 + x^3 + x^2 + 1
    localparam logic [7:0] c_POLY_LO   = 8'h1D;
    // alpha^-1 and alpha^-2 step the locator terms toward the next position
    localparam logic [7:0] c_ALPHA_M1  = 8'h8E;
    localparam logic [7:0] c_ALPHA_M2  = 8'h47;
    localparam logic [7:0] c_ALPHA     = 8'h02;
    localparam logic [2:0] c_INV_LAST  = 3'd7;
    localparam logic [4:0] c_POS_LAST  = 5'd31;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_INV    = 2'd1;
    localparam logic [1:0] S_SEARCH = 2'd2;

    // Combinational GF(2^8) multiply, shift-and-add with modular reduction
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? c_POLY_LO : 8'h00);
        end
        return p;
    endfunction

    logic [1:0] r_state;
    logic [1:0] w_state_next;

    logic [7:0] r_lambda1;
    logic [7:0] r_lambda2;
    logic [7:0] r_omega0;
    logic [7:0] r_omega1;
    logic [7:0] r_s;
    logic [7:0] r_acc;
    logic [2:0] r_k;
    logic [4:0] r_j;
    logic [7:0] r_t1;
    logic [7:0] r_t2;
    logic [7:0] r_x;
    logic [1:0] r_cnt;

    logic       r_err_valid;
    logic [4:0] r_err_pos;
    logic [7:0] r_err_val;
    logic       r_done;
    logic       r_fail;
    logic       r_busy;

    logic       w_root;
    logic       w_strobe;
    logic [7:0] w_e;
    logic [1:0] w_cnt_next;
    logic [1:0] w_deg;
    logic       w_fail;
    logic       w_last_pos;

    // State register
    always_ff @(posedge i_clk or negedge i_resb) begin
        if (!i_resb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: fixed-length INV and SEARCH phases
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:   if (i_start)               w_state_next = S_INV;
            S_INV:    if (r_k == c_INV_LAST)     w_state_next = S_SEARCH;
            S_SEARCH: if (r_j == c_POS_LAST)     w_state_next = S_IDLE;
            default:                             w_state_next = S_IDLE;
        endcase
    end

    // Per-position root test, Forney value and verdict terms
    always_comb begin
        w_root     = ((8'h01 ^ r_t1 ^ r_t2) == 8'h00);
        // lambda1 = 0 means no valid derivative, so no error is reported
        w_strobe   = w_root && (r_lambda1 != 8'h00);
        // Lambda'(x) = lambda1 in characteristic 2; r_acc holds its inverse
        w_e        = gf_mul(gf_mul(r_x, r_omega0) ^ r_omega1, r_acc);
        w_cnt_next = (w_root && (r_cnt != 2'd3)) ? (r_cnt + 2'd1) : r_cnt;
        if (r_lambda2 != 8'h00) begin
            w_deg = 2'd2;
        end else if (r_lambda1 != 8'h00) begin
            w_deg = 2'd1;
        end else begin
            w_deg = 2'd0;
        end
        w_fail     = (w_cnt_next != w_deg) ||
                     ((r_lambda1 == 8'h00) && (r_lambda2 != 8'h00));
        w_last_pos = (r_j == c_POS_LAST);
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk or negedge i_resb) begin
        if (!i_resb) begin
            r_lambda1   <= 8'h00;
            r_lambda2   <= 8'h00;
            r_omega0    <= 8'h00;
            r_omega1    <= 8'h00;
            r_s         <= 8'h00;
            r_acc       <= 8'h00;
            r_k         <= 3'd0;
            r_j         <= 5'd0;
            r_t1        <= 8'h00;
            r_t2        <= 8'h00;
            r_x         <= 8'h00;
            r_cnt       <= 2'd0;
            r_err_valid <= 1'b0;
            r_err_pos   <= 5'd0;
            r_err_val   <= 8'h00;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_err_valid <= 1'b0;
                    r_done      <= 1'b0;
                    r_fail      <= 1'b0;
                    if (i_start) begin
                        r_lambda1 <= i_lambda1;
                        r_lambda2 <= i_lambda2;
                        r_omega0  <= i_omega0;
                        r_omega1  <= i_omega1;
                        r_s       <= gf_mul(i_lambda1, i_lambda1);
                        r_acc     <= 8'h01;
                        r_k       <= 3'd1;
                        r_busy    <= 1'b1;
                    end
                end
                S_INV: begin
                    // acc accumulates lambda1^(2+4+...+128) = lambda1^254
                    r_acc <= gf_mul(r_acc, r_s);
                    r_s   <= gf_mul(r_s, r_s);
                    r_k   <= r_k + 3'd1;
                    if (r_k == c_INV_LAST) begin
                        r_j   <= 5'd0;
                        r_t1  <= r_lambda1;
                        r_t2  <= r_lambda2;
                        r_x   <= 8'h01;
                        r_cnt <= 2'd0;
                    end
                end
                S_SEARCH: begin
                    r_t1        <= gf_mul(r_t1, c_ALPHA_M1);
                    r_t2        <= gf_mul(r_t2, c_ALPHA_M2);
                    r_x         <= gf_mul(r_x, c_ALPHA);
                    r_j         <= r_j + 5'd1;
                    r_cnt       <= w_cnt_next;
                    r_err_valid <= w_strobe;
                    if (w_strobe) begin
                        r_err_pos <= r_j;
                        r_err_val <= w_e;
                    end
                    if (w_last_pos) begin
                        r_done <= 1'b1;
                        r_fail <= w_fail;
                        r_busy <= 1'b0;
                    end
                end
                default: begin
                    r_err_valid <= 1'b0;
                    r_done      <= 1'b0;
                    r_fail      <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_err_valid = r_err_valid;
    assign o_err_pos   = r_err_pos;
    assign o_err_val   = r_err_val;
    assign o_done      = r_done;
    assign o_fail      = r_fail;
    assign o_busy      = r_busy;

endmodule
`default_nettype wire
